// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the calculator read-side blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LOCKED = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam int DROP_CNT_W      = 16;
  localparam int POPSIZE_DEFAULT = 100;

  // Address width for a buffer of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int ADDR_W_DEFAULT = addr_width(POPSIZE_DEFAULT);

endpackage

// File: rtl/pop_ram.sv
// Sample RAM: one write port, one synchronous read port, and a second
// pre-read port only when POP_RUNNING_SUM_EN is defined. No reset.
module pop_ram
  import calc_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [addr_width(DEPTH)-1:0]  waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          re,
  input  logic [addr_width(DEPTH)-1:0]  raddr,
  output logic [WIDTH-1:0]              rdata
`ifdef POP_RUNNING_SUM_EN
  ,
  input  logic [addr_width(DEPTH)-1:0]  paddr,
  output logic [WIDTH-1:0]              pdata
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
`ifdef POP_RUNNING_SUM_EN
    pdata <= mem[paddr];
`endif
  end

endmodule

// File: rtl/pop_buffer.sv
// Population sample store answering the calculator read handshake.
// Optional running population sum enabled by POP_RUNNING_SUM_EN.
module pop_buffer
  import calc_pkg::*;
#(
  parameter int POPSIZE         = 100,
  parameter int DATA_WIDTH      = 8,
  parameter int UPDATE_INTERVAL = 100
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_en,
  input  logic [DATA_WIDTH-1:0]                     wr_data,
  output logic                                      wr_ready,
  input  logic                                      rd_rqst,
  input  logic [addr_width(POPSIZE)-1:0]            addr_in,
  output logic                                      data_rdy,
  output logic [DATA_WIDTH-1:0]                     data_out,
  output logic                                      new_data,
  input  logic                                      calc_done,
  output logic                                      addr_err,
  output logic [DROP_CNT_W-1:0]                     drop_cnt,
  output logic [DATA_WIDTH+$clog2(POPSIZE+1)-1:0]   pop_sum
);

  localparam int AW = addr_width(POPSIZE);
  localparam int FW = $clog2(POPSIZE + 1);
  localparam int IW = $clog2(UPDATE_INTERVAL + 1);
  localparam int SW = DATA_WIDTH + FW;

  localparam logic [AW-1:0] PTR_LAST  = AW'(POPSIZE - 1);
  localparam logic [AW:0]   POP_W     = (AW + 1)'(POPSIZE);
  localparam logic [FW-1:0] FILL_MAX  = FW'(POPSIZE);
  localparam logic [FW-1:0] FILL_LAST = FW'(POPSIZE - 1);
  localparam logic [IW-1:0] INT_LAST  = IW'(UPDATE_INTERVAL - 1);

  state_t                 state;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          wr_ptr_nxt;
  logic [AW-1:0]          base;
  logic [FW-1:0]          fill;
  logic [IW-1:0]          int_cnt;
  logic                   accept;
  logic [AW:0]            rd_sum;
  logic [AW-1:0]          rd_phys;
  logic                   rd_oor;
  logic                   out_zero;
  logic [DATA_WIDTH-1:0]  ram_q;

  assign wr_ready = (state != LOCKED);
  assign accept   = wr_en && wr_ready;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (accept) begin
      wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + AW'(1);
    end
  end

  // Logical address 0 is the oldest sample; one conditional subtract wraps it.
  assign rd_sum  = {1'b0, base} + {1'b0, addr_in};
  assign rd_phys = (rd_sum >= POP_W) ? AW'(rd_sum - POP_W) : rd_sum[AW-1:0];
  assign rd_oor  = ({1'b0, addr_in} >= POP_W);

  // Outside LOCKED base follows the write pointer, so the entering cycle captures the oldest slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      wr_ptr   <= '0;
      base     <= '0;
      fill     <= '0;
      int_cnt  <= '0;
      new_data <= 1'b0;
      drop_cnt <= '0;
    end else begin
      new_data <= 1'b0;
      wr_ptr   <= wr_ptr_nxt;
      if (state != LOCKED) begin
        base <= wr_ptr_nxt;
      end
      if (accept && (fill != FILL_MAX)) begin
        fill <= fill + FW'(1);
      end
      unique case (state)
        FILL: begin
          if (accept && (fill == FILL_LAST)) begin
            state    <= LOCKED;
            new_data <= 1'b1;
          end
        end
        LOCKED: begin
          if (wr_en && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
          end
          if (calc_done) begin
            state   <= RUN;
            int_cnt <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            if (int_cnt == INT_LAST) begin
              state    <= LOCKED;
              new_data <= 1'b1;
              int_cnt  <= '0;
            end else begin
              int_cnt <= int_cnt + IW'(1);
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // out_zero masks the RAM register after reset and for out-of-range reads, and only moves on a request.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_rdy <= 1'b0;
      addr_err <= 1'b0;
      out_zero <= 1'b1;
    end else begin
      data_rdy <= rd_rqst;
      addr_err <= rd_rqst && rd_oor;
      if (rd_rqst) begin
        out_zero <= rd_oor;
      end
    end
  end

  assign data_out = out_zero ? '0 : ram_q;

`ifdef POP_RUNNING_SUM_EN
  logic [AW-1:0]         pre_addr;
  logic [DATA_WIDTH-1:0] pre_q;
  logic [DATA_WIDTH-1:0] evict;
  logic                  fwd_valid;
  logic [DATA_WIDTH-1:0] fwd_data;

  assign pre_addr = rst ? '0 : wr_ptr_nxt;
  assign evict    = fwd_valid ? fwd_data : pre_q;
`endif

  pop_ram #(
    .DEPTH (POPSIZE),
    .WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_rqst && !rd_oor),
    .raddr (rd_phys),
    .rdata (ram_q)
`ifdef POP_RUNNING_SUM_EN
    ,
    .paddr (pre_addr),
    .pdata (pre_q)
`endif
  );

`ifdef POP_RUNNING_SUM_EN
  // The pre-read port fetches the slot the next write will evict; a one-entry buffer only matters at depth 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_sum   <= '0;
      fwd_valid <= 1'b0;
    end else begin
      fwd_valid <= accept && (wr_ptr_nxt == wr_ptr);
      if (accept) begin
        pop_sum <= pop_sum + SW'(wr_data) - ((fill == FILL_MAX) ? SW'(evict) : SW'(0));
      end
    end
  end

  always_ff @(posedge clk) begin
    fwd_data <= wr_data;
  end
`else
  assign pop_sum = '0;
`endif

endmodule

// File: tb/tb_pop_buffer.sv
// Directed bench for pop_buffer: instance 0 uses UPDATE_INTERVAL 100, instance 1 uses 10.
module tb_pop_buffer;

  localparam int POPSIZE = 100;
  localparam int DW      = 8;
  localparam int AW      = 7;
  localparam int SW      = DW + 7;
`ifdef POP_RUNNING_SUM_EN
  localparam int EXP_SUM_FULL = 300;
  localparam int EXP_SUM_NEXT = 302;
`else
  localparam int EXP_SUM_FULL = 0;
  localparam int EXP_SUM_NEXT = 0;
`endif

  typedef struct {
    string         tag;
    logic [DW-1:0] data;
    logic          err;
  } sb_entry_t;

  logic           clk;
  logic           rst       [2];
  logic           wr_en     [2];
  logic [DW-1:0]  wr_data   [2];
  logic           wr_ready  [2];
  logic           rd_rqst   [2];
  logic [AW-1:0]  addr_in   [2];
  logic           data_rdy  [2];
  logic [DW-1:0]  data_out  [2];
  logic           new_data  [2];
  logic           calc_done [2];
  logic           addr_err  [2];
  logic [15:0]    drop_cnt  [2];
  logic [SW-1:0]  pop_sum   [2];

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int nd_cnt   = 0;

  pop_buffer #(.POPSIZE(POPSIZE), .DATA_WIDTH(DW), .UPDATE_INTERVAL(100)) dut0 (
    .clk(clk), .rst(rst[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]), .wr_ready(wr_ready[0]),
    .rd_rqst(rd_rqst[0]), .addr_in(addr_in[0]), .data_rdy(data_rdy[0]), .data_out(data_out[0]),
    .new_data(new_data[0]), .calc_done(calc_done[0]), .addr_err(addr_err[0]),
    .drop_cnt(drop_cnt[0]), .pop_sum(pop_sum[0])
  );

  pop_buffer #(.POPSIZE(POPSIZE), .DATA_WIDTH(DW), .UPDATE_INTERVAL(10)) dut1 (
    .clk(clk), .rst(rst[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]), .wr_ready(wr_ready[1]),
    .rd_rqst(rd_rqst[1]), .addr_in(addr_in[1]), .data_rdy(data_rdy[1]), .data_out(data_out[1]),
    .new_data(new_data[1]), .calc_done(calc_done[1]), .addr_err(addr_err[1]),
    .drop_cnt(drop_cnt[1]), .pop_sum(pop_sum[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock; read responses are matched against the scoreboard after the edge.
  task automatic tick(input int d);
    sb_entry_t e;
    @(posedge clk);
    #1;
    if (new_data[d]) nd_cnt++;
    if (data_rdy[d] || sb_q.size() != 0) begin
      checkOutput("rd_valid", 32'(data_rdy[d]), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (data_rdy[d]) begin
          checkOutput({e.tag, "_data"}, 32'(data_out[d]), 32'(e.data));
          checkOutput({e.tag, "_err"}, 32'(addr_err[d]), 32'(e.err));
        end
      end
    end
  endtask

  task automatic applyStimulus(input int d, input logic wen, input logic [DW-1:0] wdat,
                               input logic rq, input logic [AW-1:0] addr, input logic cd,
                               input logic [DW-1:0] exp_data, input string tag);
    sb_entry_t e;
    wr_en[d]     = wen;
    wr_data[d]   = wdat;
    rd_rqst[d]   = rq;
    addr_in[d]   = addr;
    calc_done[d] = cd;
    if (rq && !rst[d]) begin
      e.tag  = tag;
      e.err  = (int'(addr) >= POPSIZE);
      e.data = e.err ? '0 : exp_data;
      sb_q.push_back(e);
    end
    tick(d);
    wr_en[d]     = 1'b0;
    rd_rqst[d]   = 1'b0;
    calc_done[d] = 1'b0;
  endtask

  task automatic write(input int d, input logic [DW-1:0] v);
    applyStimulus(d, 1'b1, v, 1'b0, '0, 1'b0, '0, "");
  endtask

  task automatic read(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v, input string tag);
    applyStimulus(d, 1'b0, '0, 1'b1, a, 1'b0, v, tag);
  endtask

  task automatic idle(input int d);
    applyStimulus(d, 1'b0, '0, 1'b0, '0, 1'b0, '0, "");
  endtask

  task automatic release_calc(input int d);
    applyStimulus(d, 1'b0, '0, 1'b0, '0, 1'b1, '0, "");
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; wr_en[k] = 1'b0; wr_data[k] = '0; rd_rqst[k] = 1'b0;
      addr_in[k] = '0; calc_done[k] = 1'b0;
    end
    idle(0);
    idle(0);
    checkOutput("rst_wr_ready", 32'(wr_ready[0]), 32'd1);
    checkOutput("rst_data_rdy", 32'(data_rdy[0]), 32'd0);
    checkOutput("rst_new_data", 32'(new_data[0]), 32'd0);
    checkOutput("rst_addr_err", 32'(addr_err[0]), 32'd0);
    checkOutput("rst_data_out", 32'(data_out[0]), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt[0]), 32'd0);
    checkOutput("rst_pop_sum", 32'(pop_sum[0]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // First population: new_data exactly once, right after the 100th write.
    nd_cnt = 0;
    for (int i = 0; i < POPSIZE; i++) write(0, DW'(i));
    checkOutput("nd_after_100th", 32'(new_data[0]), 32'd1);
    idle(0);
    checkOutput("nd_one_cycle", 32'(new_data[0]), 32'd0);
    checkOutput("nd_count_fill", 32'(nd_cnt), 32'd1);
    checkOutput("locked_wr_ready", 32'(wr_ready[0]), 32'd0);

    read(0, 7'd0, 8'd0, "rd_a0");
    read(0, 7'd1, 8'd1, "rd_a1");
    read(0, 7'd99, 8'd99, "rd_a99");
    idle(0);
    checkOutput("hold_data_out", 32'(data_out[0]), 32'd99);
    read(0, 7'd100, 8'd0, "rd_oor");
    idle(0);
    checkOutput("oor_err_pulse", 32'(addr_err[0]), 32'd0);

    for (int i = 0; i < 5; i++) write(0, 8'd77);
    checkOutput("drop_cnt_5", 32'(drop_cnt[0]), 32'd5);
    release_calc(0);
    checkOutput("run_wr_ready", 32'(wr_ready[0]), 32'd1);

    nd_cnt = 0;
    for (int i = 0; i < POPSIZE; i++) write(0, DW'(200 + i));
    checkOutput("nd_run_100", 32'(new_data[0]), 32'd1);
    checkOutput("nd_count_run", 32'(nd_cnt), 32'd1);
    read(0, 7'd0, 8'd200, "rd2_a0");
    read(0, 7'd55, 8'd255, "rd2_a55");
    read(0, 7'd99, 8'd43, "rd2_a99");
    idle(0);

    // Write coinciding with calc_done is dropped but the release still happens.
    applyStimulus(0, 1'b1, 8'd9, 1'b0, '0, 1'b1, '0, "");
    checkOutput("coinc_drop_cnt", 32'(drop_cnt[0]), 32'd6);
    checkOutput("coinc_run", 32'(wr_ready[0]), 32'd1);
    read(0, 7'd99, 8'd43, "coinc_newest");
    read(0, 7'd0, 8'd200, "coinc_oldest");
    idle(0);

    for (int i = 0; i < POPSIZE; i++) write(0, DW'(i + 1));
    checkOutput("relock_wr_ready", 32'(wr_ready[0]), 32'd0);
    rst[0] = 1'b1;
    applyStimulus(0, 1'b0, '0, 1'b1, 7'd5, 1'b0, '0, "");
    checkOutput("rst_no_rdy", 32'(data_rdy[0]), 32'd0);
    rst[0] = 1'b0;
    checkOutput("rst2_wr_ready", 32'(wr_ready[0]), 32'd1);
    checkOutput("rst2_drop_cnt", 32'(drop_cnt[0]), 32'd0);
    nd_cnt = 0;
    for (int i = 0; i < POPSIZE - 1; i++) write(0, 8'd3);
    checkOutput("nd_none_99", 32'(nd_cnt), 32'd0);
    write(0, 8'd3);
    checkOutput("nd_refill", 32'(new_data[0]), 32'd1);
    idle(0);
    checkOutput("sum_full", 32'(pop_sum[0]), 32'(EXP_SUM_FULL));
    release_calc(0);
    write(0, 8'd5);
    checkOutput("sum_evict", 32'(pop_sum[0]), 32'(EXP_SUM_NEXT));

    // Instance 1: wrap check with a ten-write update interval.
    for (int i = 0; i < POPSIZE; i++) write(1, DW'(i));
    release_calc(1);
    nd_cnt = 0;
    for (int i = 0; i < 10; i++) write(1, DW'(8'hA0 + i));
    checkOutput("w_nd_10", 32'(new_data[1]), 32'd1);
    checkOutput("w_nd_count", 32'(nd_cnt), 32'd1);
    read(1, 7'd90, 8'hA0, "w_a90");
    read(1, 7'd0, 8'd10, "w_a0");
    read(1, 7'd99, 8'hA9, "w_a99");
    read(1, 7'd89, 8'd99, "w_a89");
    idle(1);
    checkOutput("w_drop_cnt", 32'(drop_cnt[1]), 32'd0);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
